uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  8N1 UART receiver for the RS485 link: receive side of the link's transmitter.
//  Synchronises rx, qualifies start bit, samples each bit at mid-period, LSB first.
//  Emits a one-cycle po_flag with po_data on a good frame; pulses frame_err on a bad stop bit.
//  Output feeds the loopback/command logic directly; the pi_data/pi_flag pair drives the transmitter.
// PARAMETERS
//  UART_BPS   'd9600        line baud rate
//  CLK_FREQ   'd50_000_000  sys_clk frequency, Hz
//  (derived) BAUD_CNT_MAX = CLK_FREQ/UART_BPS (5208); BAUD_CNT_HALF = BAUD_CNT_MAX/2 (2604)
// PORTS
//  sys_clk    in   1  system clock, all logic on rising edge
//  sys_rst_n  in   1  asynchronous, active-low reset
//  rx         in   1  serial line, asynchronous to sys_clk, idle high
//  po_data    out  8  last good byte; holds until next good frame
//  po_flag    out  1  one-cycle pulse: po_data valid (same cycle as new po_data)
//  frame_err  out  1  one-cycle pulse: stop bit sampled 0, byte discarded
//  busy       out  1  high whenever FSM not in IDLE
// BEHAVIOUR
//  Reset: po_data=8'h00, po_flag=0, frame_err=0, busy=0, FSM=IDLE, counters=0, sync regs=1.
//  Input: 3-flop chain rx_s1/rx_s2/rx_s3; start edge = rx_s3 & ~rx_s2; all sampling uses rx_s2.
//  baud_cnt 16 bit: cleared on IDLE->START; counts 0..BAUD_CNT_MAX-1 then wraps to 0.
//  Bit sample point: baud_cnt == BAUD_CNT_HALF. bit_cnt 3 bit, 0..7, LSB first.
//  FSM:
//   IDLE : start edge -> START (baud_cnt=0). No edge -> stay.
//   START: at sample, line 1 -> IDLE (glitch, no flag, no err); line 0 -> continue;
//          at wrap -> DATA, bit_cnt=0.
//   DATA : at sample, shift sample into shift_reg[7] (right-shift); at wrap: bit_cnt==7 -> STOP,
//          else bit_cnt+1.
//   STOP : at sample: line 1 -> po_data<=shift_reg, po_flag=1 next cycle; line 0 -> frame_err=1
//          next cycle, po_data unchanged. Either way -> IDLE at that sample (no wait for end of
//          stop bit), so a start edge in the second half of stop is accepted.
//  Latency: po_flag rises 1 sys_clk after stop-bit mid-sample (~9.5 bit times after start edge,
//   plus 3-cycle sync delay).
//  po_flag and frame_err never both high; each high exactly 1 cycle per frame.
//  Start edges while not IDLE ignored (no re-sync mid-frame).
//  Line held low (break): START->DATA->STOP, frame_err pulse, then IDLE; no new start until line
//   returns high then falls again.
//  Reset mid-frame: immediate return to reset values; partial byte lost, no flag.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample = majority of rx_s2 at baud_cnt HALF-1, HALF, HALF+1;
//   decision (start check, data shift, stop check) taken at HALF+1. Single-cycle glitches rejected.
//  Not defined: single sample of rx_s2 at baud_cnt==HALF, decision at HALF.
// STRUCTURE
//  uart_pkg (shared with uart_tx): FSM state localparams S_IDLE/S_START/S_DATA/S_STOP (2 bit),
//   baud-rate helpers BAUD_CNT_MAX/BAUD_CNT_HALF as functions of CLK_FREQ, UART_BPS.
//  One sub-module: uart_rx_sync (3-flop synchroniser + falling-edge detect, reset to 1).
//  Top holds FSM, baud/bit counters, shift register, output registers.
// TESTING (CLK_FREQ=50M, UART_BPS=9600, bit = 5208 clocks)
//  1. Send 8'h55, stop=1 -> one po_flag, po_data=8'h55, frame_err never high, busy low after.
//  2. Send 8'hA3 then 8'h0F back-to-back, no idle gap -> two po_flag pulses, 8'hA3 then 8'h0F.
//  3. rx low for 1000 clocks then high -> FSM returns IDLE at mid-start, no flag, no err.
//  4. Send 8'hC4 with stop bit 0 -> frame_err one cycle, no po_flag, po_data keeps previous value.
//  5. Assert sys_rst_n=0 during bit 4 of 8'h3C, release, send 8'h81 -> only po_data=8'h81 flagged.
//  6. UART_RX_MAJORITY_EN: 1-clock high glitch at HALF of data bit 2 in 8'h00 -> po_data=8'h00;
//     without macro, glitch exactly at HALF -> po_data=8'h04.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Definitions shared by the UART receiver and transmitter. Holds
//           the frame FSM state encoding and the baud-rate divider helpers.
// Contents:
//   uart_state_e   2-bit FSM state (S_IDLE, S_START, S_DATA, S_STOP)
//   baud_cnt_max   sys_clk cycles per bit  = CLK_FREQ / UART_BPS
//   baud_cnt_half  mid-bit sample offset   = baud_cnt_max / 2
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int unsigned baud_cnt_half(input int unsigned clk_freq,
                                                input int unsigned uart_bps);
    return baud_cnt_max(clk_freq, uart_bps) / 2;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_sync
// Purpose : Three-flop synchroniser for the asynchronous serial line plus
//           falling-edge (start-edge) detection. Flops reset to 1 (idle line)
//           so that reset release never creates a false start edge.
// Ports   :
//   clk_i         in   1  system clock
//   rst_ni        in   1  asynchronous active-low reset
//   rx_i          in   1  raw serial line
//   rx_sync_o     out  1  second synchroniser stage (used for all sampling)
//   start_edge_o  out  1  third stage high while second stage low
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic start_edge_o
);

  // sync_q[0] = rx_s1, sync_q[1] = rx_s2, sync_q[2] = rx_s3
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
    end
  end

  assign rx_sync_o    = sync_q[1];
  assign start_edge_o = sync_q[2] & ~sync_q[1];

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_frame
// Purpose : 8N1 UART receiver. Qualifies the start bit at mid-period, shifts
//           eight data bits LSB first, checks the stop bit. A good frame
//           loads po_data and pulses po_flag for one cycle; a stop bit of 0
//           pulses frame_err for one cycle and discards the byte.
// Config  : UART_RX_MAJORITY_EN - when defined, each bit is the majority of
//           three samples at HALF-1/HALF/HALF+1 with the decision at HALF+1;
//           otherwise a single sample is taken and decided at HALF.
// Ports   :
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   rx         in   1  serial line, idle high
//   po_data    out  8  last good byte
//   po_flag    out  1  one-cycle pulse, po_data updated
//   frame_err  out  1  one-cycle pulse, bad stop bit
//   busy       out  1  FSM not idle
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
  parameter int unsigned UART_BPS = 'd9600,
  parameter int unsigned CLK_FREQ = 'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int unsigned BAUD_CNT_MAX  = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned BAUD_CNT_HALF = baud_cnt_half(CLK_FREQ, UART_BPS);
  localparam logic [15:0] CNT_LAST      = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] CNT_HALF      = 16'(BAUD_CNT_HALF);

  logic        rx_s2;
  logic        start_edge;

  uart_state_e state_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  po_data_q;
  logic        po_flag_q;
  logic        frame_err_q;

  logic        baud_wrap;
  logic        sample_now;
  logic        sample_bit;

  uart_rx_sync u_sync (
    .clk_i        (sys_clk),
    .rst_ni       (sys_rst_n),
    .rx_i         (rx),
    .rx_sync_o    (rx_s2),
    .start_edge_o (start_edge)
  );

  assign baud_wrap = (baud_cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] CNT_PRE  = 16'(BAUD_CNT_HALF - 1);
  localparam logic [15:0] CNT_POST = 16'(BAUD_CNT_HALF + 1);

  // Early samples at HALF-1 and HALF; the third is rx_s2 itself at HALF+1.
  logic [1:0] maj_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      maj_q <= 2'b11;
    end else begin
      if (baud_cnt_q == CNT_PRE)  maj_q[0] <= rx_s2;
      if (baud_cnt_q == CNT_HALF) maj_q[1] <= rx_s2;
    end
  end

  assign sample_now = (baud_cnt_q == CNT_POST);
  assign sample_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s2) | (maj_q[1] & rx_s2);
`else
  assign sample_now = (baud_cnt_q == CNT_HALF);
  assign sample_bit = rx_s2;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      po_data_q   <= 8'h00;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;

      // Counter is held at zero in IDLE so every frame starts from a clean count.
      if (state_q == S_IDLE) begin
        baud_cnt_q <= 16'd0;
      end else if (baud_wrap) begin
        baud_cnt_q <= 16'd0;
      end else begin
        baud_cnt_q <= baud_cnt_q + 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_edge) state_q <= S_START;
        end
        S_START: begin
          // High at mid-start means the falling edge was a glitch.
          if (sample_now && sample_bit) begin
            state_q <= S_IDLE;
          end else if (baud_wrap) begin
            state_q   <= S_DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        S_DATA: begin
          if (sample_now) shift_q <= {sample_bit, shift_q[7:1]};
          if (baud_wrap) begin
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        S_STOP: begin
          // Leave at mid-stop so a start edge in the second half is caught.
          if (sample_now) begin
            state_q <= S_IDLE;
            if (sample_bit) begin
              po_data_q <= shift_q;
              po_flag_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule : uart_rx_frame
`default_nettype wire
